// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler for the 32x32 register bank: arbitrates ALU and memory
// writebacks onto the single write port and tracks pending writes for issue hazards.
module regfile_wb_scheduler #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rs1,
  input  logic [4:0]       issue_rs2,
  input  logic [4:0]       issue_rd,
  input  logic             issue_wr,
  output logic             issue_stall,
  input  logic             alu_wb_valid,
  input  logic [4:0]       alu_wb_rd,
  input  logic [WIDTH-1:0] alu_wb_data,
  output logic             alu_wb_ready,
  input  logic             mem_wb_valid,
  input  logic [4:0]       mem_wb_rd,
  input  logic [WIDTH-1:0] mem_wb_data,
  output logic             mem_wb_ready,
  output logic             rf_we,
  output logic [4:0]       rf_rd,
  output logic [WIDTH-1:0] rf_wdata,
  output logic [31:0]      pending
);

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_MEM = 1'b1
  } grant_e;

  grant_e      last_grant;
  logic        grant_alu;
  logic        grant_mem;
  logic [31:0] pending_set;
  logic [31:0] pending_clr;

  // Handshake: a requester raises valid with a stable rd/data and holds both
  // until it sees ready in the same cycle; valid && ready is the transfer, and
  // ready never waits on anything but the other requester's valid.
  always_comb begin
    grant_alu = alu_wb_valid && (!mem_wb_valid || (last_grant == GRANT_MEM));
    grant_mem = mem_wb_valid && !grant_alu;
    alu_wb_ready = grant_alu;
    mem_wb_ready = grant_mem;
  end

  // Hazards are judged against registered pending only; there is no bypass.
  always_comb begin
    issue_stall = issue_valid &&
                  (pending[issue_rs1] || pending[issue_rs2] ||
                   (issue_wr && pending[issue_rd]));
    pending_set = '0;
    if (issue_valid && issue_wr && !issue_stall && (issue_rd != 5'd0))
      pending_set[issue_rd] = 1'b1;
    pending_clr = '0;
    if (rf_we)
      pending_clr[rf_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending    <= '0;
      rf_we      <= 1'b0;
      rf_rd      <= '0;
      rf_wdata   <= '0;
      last_grant <= GRANT_MEM;
    end else begin
      pending <= ((pending & ~pending_clr) | pending_set) & 32'hFFFF_FFFE;
      rf_we   <= 1'b0;
      if (grant_alu) begin
        last_grant <= GRANT_ALU;
        if (alu_wb_rd != 5'd0) begin
          rf_we    <= 1'b1;
          rf_rd    <= alu_wb_rd;
          rf_wdata <= alu_wb_data;
        end
      end else if (grant_mem) begin
        last_grant <= GRANT_MEM;
        // x0 writes are consumed here so the bank never sees them.
        if (mem_wb_rd != 5'd0) begin
          rf_we    <= 1'b1;
          rf_rd    <= mem_wb_rd;
          rf_wdata <= mem_wb_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed scenarios then random traffic, all
// compared each cycle against a behavioural model of the scheduler.
module tb_regfile_wb_scheduler;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         issue_valid = 1'b0;
  logic [4:0]   issue_rs1 = '0;
  logic [4:0]   issue_rs2 = '0;
  logic [4:0]   issue_rd = '0;
  logic         issue_wr = 1'b0;
  logic         issue_stall;
  logic         alu_wb_valid = 1'b0;
  logic [4:0]   alu_wb_rd = '0;
  logic [W-1:0] alu_wb_data = '0;
  logic         alu_wb_ready;
  logic         mem_wb_valid = 1'b0;
  logic [4:0]   mem_wb_rd = '0;
  logic [W-1:0] mem_wb_data = '0;
  logic         mem_wb_ready;
  logic         rf_we;
  logic [4:0]   rf_rd;
  logic [W-1:0] rf_wdata;
  logic [31:0]  pending;

  regfile_wb_scheduler #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .issue_wr(issue_wr), .issue_stall(issue_stall),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
    .alu_wb_ready(alu_wb_ready),
    .mem_wb_valid(mem_wb_valid), .mem_wb_rd(mem_wb_rd), .mem_wb_data(mem_wb_data),
    .mem_wb_ready(mem_wb_ready),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .pending(pending)
  );

  // Clock and reset
  always #5 clk = ~clk;

  // Scoreboard and reference model state
  int            checks = 0;
  int            errors = 0;
  logic [31:0]   m_pend;
  bit            m_last_alu;
  logic [4:0]    m_rd;
  logic [W-1:0]  m_wd;
  logic [W+4:0]  exp_q[$];
  bit            alu_acc = 1'b0;
  bit            mem_acc = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0;
    m_last_alu = 1'b0;
    m_rd = '0;
    m_wd = '0;
    exp_q.delete();
  endtask

  // One clock cycle: inputs already driven after the falling edge.
  task automatic cycle();
    bit g_alu, g_mem, stall;
    logic [W+4:0] w;
    #1;
    g_alu = alu_wb_valid && (!mem_wb_valid || !m_last_alu);
    g_mem = mem_wb_valid && !g_alu;
    stall = issue_valid && (m_pend[issue_rs1] || m_pend[issue_rs2] ||
                            (issue_wr && m_pend[issue_rd]));
    check("alu_ready", alu_wb_ready, g_alu);
    check("mem_ready", mem_wb_ready, g_mem);
    check("stall", issue_stall, stall);
    check("pending", pending, m_pend);
    if (exp_q.size() > 0) begin
      w = exp_q[0];
      check("rf_we", rf_we, 1'b1);
      check("rf_rd", rf_rd, w[W+4:W]);
      check("rf_wdata", rf_wdata, w[W-1:0]);
    end else begin
      check("rf_we", rf_we, 1'b0);
      check("rf_rd_hold", rf_rd, m_rd);
      check("rf_wdata_hold", rf_wdata, m_wd);
    end
    alu_acc = rst_n && g_alu;
    mem_acc = rst_n && g_mem;
    if (!rst_n) begin
      model_reset();
    end else begin
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        m_pend[w[W+4:W]] = 1'b0;
        m_rd = w[W+4:W];
        m_wd = w[W-1:0];
      end
      if (issue_valid && issue_wr && !stall && issue_rd != 5'd0)
        m_pend[issue_rd] = 1'b1;
      if (alu_acc) begin
        m_last_alu = 1'b1;
        if (alu_wb_rd != 5'd0) exp_q.push_back({alu_wb_rd, alu_wb_data});
      end
      if (mem_acc) begin
        m_last_alu = 1'b0;
        if (mem_wb_rd != 5'd0) exp_q.push_back({mem_wb_rd, mem_wb_data});
      end
    end
    @(negedge clk);
  endtask

  // Driver tasks
  task automatic drive_issue(input bit v, input bit wr, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2);
    issue_valid = v; issue_wr = wr; issue_rd = rd; issue_rs1 = rs1; issue_rs2 = rs2;
  endtask

  task automatic drive_alu(input bit v, input logic [4:0] rd, input logic [W-1:0] d);
    alu_wb_valid = v; alu_wb_rd = rd; alu_wb_data = d;
  endtask

  task automatic drive_mem(input bit v, input logic [4:0] rd, input logic [W-1:0] d);
    mem_wb_valid = v; mem_wb_rd = rd; mem_wb_data = d;
  endtask

  function automatic logic [4:0] pick_rd();
    logic [4:0] cand[$];
    for (int i = 1; i < 32; i++) if (m_pend[i]) cand.push_back(5'(i));
    if (cand.size() > 0 && $urandom_range(0, 99) < 70)
      return cand[$urandom_range(0, cand.size() - 1)];
    if ($urandom_range(0, 9) == 0) return 5'd0;
    return 5'($urandom_range(1, 31));
  endfunction

  initial begin
    // Reset held two cycles with both requesters valid
    drive_alu(1'b1, 5'd1, 32'h11);
    drive_mem(1'b1, 5'd2, 32'h22);
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    #1;
    check("rst_pending", pending, 32'd0);
    check("rst_rf_we", rf_we, 1'b0);
    check("rst_tie_alu", alu_wb_ready, 1'b1);
    check("rst_tie_mem", mem_wb_ready, 1'b0);
    cycle();
    drive_alu(1'b0, 5'd0, '0);
    cycle();
    drive_mem(1'b0, 5'd0, '0);
    repeat (2) cycle();

    // Single ALU write to x5
    drive_issue(1'b1, 1'b1, 5'd5, 5'd0, 5'd0);
    cycle();
    drive_issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    #1 check("pend5_set", pending[5], 1'b1);
    drive_alu(1'b1, 5'd5, 32'hDEADBEEF);
    #1 check("alu5_ready", alu_wb_ready, 1'b1);
    cycle();
    drive_alu(1'b0, 5'd0, '0);
    #1;
    check("wr5_we", rf_we, 1'b1);
    check("wr5_rd", rf_rd, 5'd5);
    check("wr5_data", rf_wdata, 32'hDEADBEEF);
    cycle();
    #1 check("pend5_clr", pending[5], 1'b0);
    cycle();

    // RAW stall on x7
    drive_issue(1'b1, 1'b1, 5'd7, 5'd0, 5'd0);
    cycle();
    drive_issue(1'b1, 1'b0, 5'd0, 5'd7, 5'd0);
    #1 check("raw_stall", issue_stall, 1'b1);
    repeat (2) cycle();
    drive_alu(1'b1, 5'd7, 32'h0000_0777);
    cycle();
    drive_alu(1'b0, 5'd0, '0);
    #1 check("raw_stall_at_we", issue_stall, 1'b1);
    cycle();
    #1 check("raw_stall_drop", issue_stall, 1'b0);
    cycle();
    drive_issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);

    // x0 handling
    drive_issue(1'b1, 1'b1, 5'd0, 5'd0, 5'd0);
    #1 check("x0_nostall", issue_stall, 1'b0);
    cycle();
    drive_issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    #1 check("x0_pending", pending, 32'd0);
    drive_mem(1'b1, 5'd0, 32'hFFFF);
    #1 check("x0_mem_ready", mem_wb_ready, 1'b1);
    cycle();
    drive_mem(1'b0, 5'd0, '0);
    #1 check("x0_no_we", rf_we, 1'b0);
    cycle();

    // Round-robin with both requesters busy for three cycles
    drive_alu(1'b1, 5'd3, 32'd1);
    drive_mem(1'b1, 5'd4, 32'd2);
    cycle();
    #1 check("rr_rd0", rf_rd, 5'd3);
    cycle();
    #1 check("rr_rd1", rf_rd, 5'd4);
    cycle();
    drive_alu(1'b0, 5'd0, '0);
    #1;
    check("rr_rd2", rf_rd, 5'd3);
    check("rr_we2", rf_we, 1'b1);
    cycle();
    drive_mem(1'b0, 5'd0, '0);
    repeat (2) cycle();

    // Reset in the middle of operation
    drive_issue(1'b1, 1'b1, 5'd5, 5'd0, 5'd0);
    cycle();
    drive_issue(1'b1, 1'b1, 5'd9, 5'd0, 5'd0);
    cycle();
    drive_issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    drive_mem(1'b1, 5'd9, 32'hBAD0_0009);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    drive_mem(1'b0, 5'd0, '0);
    #1;
    check("mid_rst_pending", pending, 32'd0);
    check("mid_rst_we", rf_we, 1'b0);
    cycle();
    #1 check("mid_rst_dropped", rf_we, 1'b0);
    cycle();

    // Randomized traffic; requesters hold valid and payload until accepted
    alu_acc = 1'b0;
    mem_acc = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      drive_issue($urandom_range(0, 99) < 70, $urandom_range(0, 1),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)));
      if (!alu_wb_valid || alu_acc)
        drive_alu($urandom_range(0, 99) < 55, pick_rd(), $urandom);
      if (!mem_wb_valid || mem_acc)
        drive_mem($urandom_range(0, 99) < 55, pick_rd(), $urandom);
      rst_n = ($urandom_range(0, 399) != 0);
      cycle();
    end
    rst_n = 1'b1;
    drive_issue(1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    drive_alu(1'b0, 5'd0, '0);
    drive_mem(1'b0, 5'd0, '0);
    repeat (2) cycle();

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
